// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcode map, ALU
// function codes, PC source selects and the sequencer state encoding.
package cpu_pkg;

  // Instruction opcodes (ir_op field)
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SUBC = 4'b0101;
  localparam logic [3:0] OP_ADDC = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_ANDI = 4'b1000;
  localparam logic [3:0] OP_ORI  = 4'b1001;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  // ALU function codes
  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_ADDC = 4'b0100;
  localparam logic [3:0] ALUC_SUBC = 4'b0101;
  localparam logic [3:0] ALUC_SLT  = 4'b0110;
  localparam logic [3:0] ALUC_MUL  = 4'b1000;
  localparam logic [3:0] ALUC_NONE = 4'b0000;

  // PC source selects
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing signal bundle of the multi-cycle controller. The master
// side is the controller; the slave side is the datapath / memories.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [3:0]       ir_op;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             stall;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic [3:0]       alu_op;
  logic             alu_src_b;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             flag_write;
  logic             busy;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ir_op, zero, imem_ready, dmem_ready, stall,
    output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_b,
           dmem_req, dmem_we, reg_write, mem_to_reg, reg_dst, flag_write,
           busy, instr_done, retired
  );

  modport slave (
    output ir_op, zero, imem_ready, dmem_ready, stall,
    input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_b,
           dmem_req, dmem_we, reg_write, mem_to_reg, reg_dst, flag_write,
           busy, instr_done, retired
  );
endinterface

// File: rtl/op_decode.sv
// Combinational per-opcode attribute table used by the sequencer.
module op_decode
  import cpu_pkg::*;
(
  input  logic [3:0] ir_op,
  output logic [3:0] alu_op,
  output logic       imm,
  output logic       is_mem,
  output logic       is_branch,
  output logic       writes_rd,
  output logic       writes_flag
);

  // Map opcode to ALU code and instruction-class attributes
  always_comb begin
    alu_op      = ALUC_NONE;
    imm         = 1'b0;
    is_mem      = 1'b0;
    is_branch   = 1'b0;
    writes_rd   = 1'b0;
    writes_flag = 1'b0;
    case (ir_op)
      OP_AND:  begin alu_op = ALUC_AND;  writes_rd = 1'b1; end
      OP_OR:   begin alu_op = ALUC_OR;   writes_rd = 1'b1; end
      OP_ADD:  begin alu_op = ALUC_ADD;  writes_rd = 1'b1; writes_flag = 1'b1; end
      OP_SUB:  begin alu_op = ALUC_SUB;  writes_rd = 1'b1; writes_flag = 1'b1; end
      OP_SLT:  begin alu_op = ALUC_SLT;  writes_rd = 1'b1; end
      OP_SUBC: begin alu_op = ALUC_SUBC; writes_rd = 1'b1; writes_flag = 1'b1; end
      OP_ADDC: begin alu_op = ALUC_ADDC; writes_rd = 1'b1; writes_flag = 1'b1; end
      OP_JMP:  begin alu_op = ALUC_NONE; end
      OP_ANDI: begin alu_op = ALUC_AND;  imm = 1'b1; end
      OP_ORI:  begin alu_op = ALUC_OR;   imm = 1'b1; end
      OP_ADDI: begin alu_op = ALUC_ADD;  imm = 1'b1; writes_flag = 1'b1; end
      OP_LW:   begin alu_op = ALUC_ADD;  imm = 1'b1; is_mem = 1'b1; end
      OP_SW:   begin alu_op = ALUC_ADD;  imm = 1'b1; is_mem = 1'b1; end
      OP_BEQ:  begin alu_op = ALUC_SUB;  is_branch = 1'b1; end
      OP_BNE:  begin alu_op = ALUC_SUB;  is_branch = 1'b1; end
      OP_MUL:  begin alu_op = ALUC_MUL;  writes_rd = 1'b1; writes_flag = 1'b1; end
      default: begin alu_op = ALUC_NONE; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with wait-stated
// memories, an iterative MUL held in EXEC, an external freeze and a
// retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);

  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LAT - 1);

  state_t           state_r, state_nxt;
  logic [MC_W-1:0]  mul_cnt_r, mul_cnt_nxt;
  logic [CNT_W-1:0] retired_r;

  logic [3:0] dec_alu_op;
  logic       dec_imm, dec_is_mem, dec_is_branch, dec_writes_rd, dec_writes_flag;

  logic       imem_req_s, ir_write_s, pc_write_s, dmem_req_s, dmem_we_s;
  logic       reg_write_s, mem_to_reg_s, reg_dst_s, flag_write_s;
  logic       busy_s, instr_done_s, alu_src_b_s;
  logic [1:0] pc_src_s;
  logic [3:0] alu_op_s;

  op_decode u_op_decode (
    .ir_op       (bus.ir_op),
    .alu_op      (dec_alu_op),
    .imm         (dec_imm),
    .is_mem      (dec_is_mem),
    .is_branch   (dec_is_branch),
    .writes_rd   (dec_writes_rd),
    .writes_flag (dec_writes_flag)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= FETCH;
    else     state_r <= state_nxt;
  end

  // MUL iteration counter
  always_ff @(posedge clk) begin
    if (rst) mul_cnt_r <= {MC_W{1'b0}};
    else     mul_cnt_r <= mul_cnt_nxt;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)               retired_r <= {CNT_W{1'b0}};
    else if (instr_done_s) retired_r <= retired_r + CNT_W'(1);
    else                   retired_r <= retired_r;
  end

  // Next-state and MUL counter logic; a stall freezes everything
  always_comb begin
    state_nxt   = state_r;
    mul_cnt_nxt = mul_cnt_r;
    if (bus.stall) begin
      state_nxt   = state_r;
      mul_cnt_nxt = mul_cnt_r;
    end else begin
      case (state_r)
        FETCH: begin
          if (bus.imem_ready) state_nxt = DECODE;
          else                state_nxt = FETCH;
        end
        DECODE: begin
          if (bus.ir_op == OP_JMP) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = EXEC;
            if (bus.ir_op == OP_MUL) mul_cnt_nxt = MUL_LOAD;
            else                     mul_cnt_nxt = mul_cnt_r;
          end
        end
        EXEC: begin
          if (dec_is_branch) begin
            state_nxt = FETCH;
          end else if (dec_is_mem) begin
            state_nxt = MEM;
          end else if (bus.ir_op == OP_MUL) begin
            // Counter reaching zero marks the last EXEC cycle of MUL
            if (mul_cnt_r != {MC_W{1'b0}}) begin
              state_nxt   = EXEC;
              mul_cnt_nxt = mul_cnt_r - MC_W'(1);
            end else begin
              state_nxt = WB;
            end
          end else begin
            state_nxt = WB;
          end
        end
        MEM: begin
          if (!bus.dmem_ready)          state_nxt = MEM;
          else if (bus.ir_op == OP_SW)  state_nxt = FETCH;
          else                          state_nxt = WB;
        end
        WB:      state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Per-state control outputs; reset blanks all, stall blanks strobes only
  always_comb begin
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = PC_SRC_SEQ;
    alu_op_s     = ALUC_NONE;
    alu_src_b_s  = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_dst_s    = 1'b0;
    flag_write_s = 1'b0;
    busy_s       = 1'b0;
    instr_done_s = 1'b0;
    if (!rst) begin
      busy_s = (state_r != FETCH);
      if (state_r == EXEC || state_r == MEM || state_r == WB) begin
        alu_op_s    = dec_alu_op;
        alu_src_b_s = dec_imm;
      end else begin
        alu_op_s    = ALUC_NONE;
        alu_src_b_s = 1'b0;
      end
      case (state_r)
        FETCH: begin
          imem_req_s = 1'b1;
          if (bus.imem_ready) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            pc_src_s   = PC_SRC_SEQ;
          end else begin
            ir_write_s = 1'b0;
          end
        end
        DECODE: begin
          if (bus.ir_op == OP_JMP) begin
            pc_write_s   = 1'b1;
            pc_src_s     = PC_SRC_JUMP;
            instr_done_s = 1'b1;
          end else begin
            pc_write_s = 1'b0;
          end
        end
        EXEC: begin
          if (dec_is_branch) begin
            pc_src_s     = PC_SRC_BRANCH;
            pc_write_s   = (bus.ir_op == OP_BEQ) ? bus.zero : !bus.zero;
            instr_done_s = 1'b1;
          end else begin
            pc_write_s = 1'b0;
          end
        end
        MEM: begin
          dmem_req_s = 1'b1;
          dmem_we_s  = (bus.ir_op == OP_SW);
          if (bus.dmem_ready && bus.ir_op == OP_SW) instr_done_s = 1'b1;
          else                                      instr_done_s = 1'b0;
        end
        WB: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = (bus.ir_op == OP_LW);
          reg_dst_s    = dec_writes_rd;
          flag_write_s = dec_writes_flag;
          instr_done_s = 1'b1;
        end
        default: begin
          busy_s = 1'b1;
        end
      endcase
      if (bus.stall) begin
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        flag_write_s = 1'b0;
        instr_done_s = 1'b0;
      end else begin
        instr_done_s = instr_done_s;
      end
    end else begin
      busy_s = 1'b0;
    end
  end

  assign bus.imem_req   = imem_req_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.dmem_req   = dmem_req_s;
  assign bus.dmem_we    = dmem_we_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.flag_write = flag_write_s;
  assign bus.busy       = busy_s;
  assign bus.instr_done = instr_done_s;
  assign bus.retired    = rst ? {CNT_W{1'b0}} : retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (MUL_LAT=4, CNT_W=4).
module tb_multicycle_ctrl;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;

  localparam logic [3:0] T_ADD = 4'b0010;
  localparam logic [3:0] T_JMP = 4'b0111;
  localparam logic [3:0] T_LW  = 4'b1011;
  localparam logic [3:0] T_SW  = 4'b1100;
  localparam logic [3:0] T_BEQ = 4'b1101;
  localparam logic [3:0] T_BNE = 4'b1110;
  localparam logic [3:0] T_MUL = 4'b1111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {strobes(8), pc_src(2), alu_op(4), alu_src_b, mem_to_reg, reg_dst, busy, retired(4)}
  // strobes = {imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write, flag_write, instr_done}
  logic [21:0] act;
  assign act = {bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.dmem_we,
                bus.reg_write, bus.flag_write, bus.instr_done, bus.pc_src, bus.alu_op,
                bus.alu_src_b, bus.mem_to_reg, bus.reg_dst, bus.busy, bus.retired};

  typedef struct packed {
    logic        r;
    logic [3:0]  op;
    logic        z;
    logic        ir;
    logic        dr;
    logic        st;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [3:0] exp_ret;

  task automatic add(input logic r, input logic [3:0] op, input logic z, input logic ir,
                     input logic dr, input logic st, input logic [7:0] strb,
                     input logic [1:0] pcs, input logic [3:0] aop, input logic sb,
                     input logic m2r, input logic rd, input logic bsy, input logic [3:0] ret);
    vec_t v;
    v.r = r; v.op = op; v.z = z; v.ir = ir; v.dr = dr; v.st = st;
    v.exp = {strb, pcs, aop, sb, m2r, rd, bsy, ret};
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and let outputs settle
  task automatic step(input logic r, input logic [3:0] op, input logic z, input logic ir,
                      input logic dr, input logic st);
    @(negedge clk);
    rst = r; bus.ir_op = op; bus.zero = z;
    bus.imem_ready = ir; bus.dmem_ready = dr; bus.stall = st;
    #2;
  endtask

  initial begin
    rst = 1'b1; bus.ir_op = 4'b0000; bus.zero = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.stall = 1'b0;

    // reset, then idle fetch
    add(1'b1, T_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, T_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, T_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    // ADD: 4 cycles
    add(1'b0, T_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, T_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, T_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, T_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0111, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    // LW with dmem_ready late by 3 cycles: 8 cycles
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b0001_0000, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b0001_0000, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b0, 1'b0, 8'b0001_0000, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b1, 1'b0, 8'b0001_0000, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, T_LW,  1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0101, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
    // BEQ taken (zero=1)
    add(1'b0, T_BEQ, 1'b1, 1'b1, 1'b1, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, T_BEQ, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    add(1'b0, T_BEQ, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0010_0001, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    // BNE not taken (zero=1)
    add(1'b0, T_BNE, 1'b1, 1'b1, 1'b1, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, T_BNE, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    add(1'b0, T_BNE, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_0001, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    // JMP retires from DECODE
    add(1'b0, T_JMP, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    add(1'b0, T_JMP, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0010_0001, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    // MUL: 4 EXEC cycles stretched to 6 by a 2-cycle stall, then a stalled WB
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1110_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    add(1'b0, T_MUL, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0111, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    // stall in FETCH swallows imem_ready
    add(1'b0, T_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 8'b0000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
    add(1'b0, T_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].op, vecs[i].z, vecs[i].ir, vecs[i].dr, vecs[i].st);
      cmp($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end

    // SW abandoned by reset in MEM: no retire, no further dmem_we
    step(1'b0, T_SW, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("sw_fetch_irw", 32'(bus.ir_write), 32'd1);
    step(1'b0, T_SW, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, T_SW, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("sw_exec_srcb", 32'(bus.alu_src_b), 32'd1);
    step(1'b0, T_SW, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("sw_mem_req_we_done", 32'({bus.dmem_req, bus.dmem_we, bus.instr_done}), 32'd6);
    step(1'b1, T_SW, 1'b0, 1'b1, 1'b1, 1'b1);
    cmp("sw_rst_all_zero", 32'(act), 32'd0);
    step(1'b0, T_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("sw_rst_after", 32'({bus.imem_req, bus.busy, bus.retired}), 32'h20);

    // retired wraps after 16 JMPs with CNT_W=4
    exp_ret = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, T_JMP, 1'b0, 1'b1, 1'b0, 1'b0);
      cmp($sformatf("wrap_ret%0d", i), 32'(bus.retired), 32'(exp_ret));
      step(1'b0, T_JMP, 1'b0, 1'b1, 1'b0, 1'b0);
      cmp($sformatf("wrap_done%0d", i), 32'({bus.instr_done, bus.pc_src}), 32'd6);
      exp_ret = exp_ret + 4'd1;
    end
    step(1'b0, T_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("wrap_final", 32'(bus.retired), 32'(exp_ret));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the 4-bit-opcode CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the PC, IR, register-file, ALU and data-memory controls per state. It supports wait-stated instruction and data memories, an iterative multi-cycle MUL, and an external freeze. It sits between the IR/ALU flags and the datapath, replacing the single-cycle decoder.

Parameters:
MUL_LAT, 4, number of EXEC cycles held for MUL (≥1)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ir_op  in  4  opcode field of the instruction register (stable from DECODE onward)
zero  in  1  ALU zero flag (valid in EXEC)
imem_ready  in  1  instruction-memory data valid
dmem_ready  in  1  data-memory access complete
stall  in  1  external freeze
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target
alu_op  out  4  ALU function code
alu_src_b  out  1  1 = immediate operand
dmem_req  out  1  data-memory request
dmem_we  out  1  data-memory write
reg_write  out  1  register-file write strobe
mem_to_reg  out  1  write-back selects memory data
reg_dst  out  1  1 = rd, 0 = rt
flag_write  out  1  update carry/overflow flags
busy  out  1  high whenever state ≠ FETCH
instr_done  out  1  one-cycle pulse when an instruction retires
retired  out  CNT_W  count of retired instructions

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst. While rst is high, every output is 0 and retired is 0.
- On the first clock edge with rst high, state becomes FETCH, the MUL counter is cleared and retired is cleared.
- Outputs are combinational from state, ir_op, zero and stall. Only state, the MUL counter and retired are registered.
- Opcode map and ALU codes:
  - AND 0000 → 0000; OR 0001 → 0001; ADD 0010 → 0010; SUB 0011 → 0011.
  - SLT 0100 → 0110; SUBC 0101 → 0101; ADDC 0110 → 0100; JMP 0111 → none.
  - ANDI 1000 → 0000; ORI 1001 → 0001; ADDI 1010 → 0010.
  - LW 1011 → 0010; SW 1100 → 0010; BEQ 1101 → 0011; BNE 1110 → 0011; MUL 1111 → 1000.
- alu_op and alu_src_b are driven from ir_op in EXEC, MEM and WB, and are 0 otherwise.
- Immediate class (alu_src_b=1): ANDI, ORI, ADDI, LW, SW.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE:
  - JMP: pc_write=1, pc_src=2, instr_done=1, next state FETCH.
  - MUL: MUL counter loads MUL_LAT-1, next state EXEC.
  - All other opcodes: next state EXEC.
- EXEC:
  - BEQ: pc_write=zero, pc_src=1, instr_done=1, next state FETCH.
  - BNE: pc_write=!zero, pc_src=1, instr_done=1, next state FETCH.
  - LW/SW: next state MEM.
  - MUL: counter decrements each cycle; stays in EXEC while counter ≠ 0, then WB. Total EXEC residency is exactly MUL_LAT cycles; MUL_LAT=1 behaves like ADD timing.
  - All other opcodes: next state WB.
- MEM:
  - dmem_req=1; dmem_we=1 for SW.
  - Holds until dmem_ready.
  - SW on dmem_ready: instr_done=1, next state FETCH.
  - LW on dmem_ready: next state WB.
- WB:
  - reg_write=1, mem_to_reg=(LW).
  - reg_dst=1 for AND, OR, ADD, SUB, SLT, SUBC, ADDC, MUL.
  - flag_write=1 for ADD, SUB, ADDC, SUBC, ADDI, MUL.
  - instr_done=1, next state FETCH.
- Branches and SW never assert reg_write.
- retired increments on every instr_done cycle and wraps at 2^CNT_W-1 → 0.
- stall=1:
  - State, MUL counter and retired hold.
  - imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, flag_write and instr_done are forced 0.
  - A ready arriving during stall is ignored. The requester must re-present ready after stall drops.
  - alu_op, alu_src_b, mem_to_reg, reg_dst and pc_src keep their decoded values.
- Simultaneous rst with stall or ready: rst wins. Reset mid-MUL or mid-MEM abandons the instruction, with no retire and no write strobe.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams (OP_AND … OP_MUL);
  - the ALU code localparams (ALUC_AND … ALUC_MUL);
  - the pc_src codes;
  - the state encoding (FETCH, DECODE, EXEC, MEM, WB).
- One sub-module, op_decode: a combinational map of ir_op to the per-opcode attributes alu_op, imm, is_mem, is_branch, writes_rd, writes_flag.
- The FSM, MUL counter and retire counter stay in multicycle_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles, then released with imem_ready=0 → all outputs 0 during reset; then imem_req=1, busy=0, retired=0.
- ADD with ir_op=0010 and imem_ready/dmem_ready tied 1 → exactly 4 cycles per instruction. The WB cycle shows reg_write=1, reg_dst=1, flag_write=1, alu_op=0010. retired increments by 1.
- LW with ir_op=1011 and dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0. Then WB with mem_to_reg=1, reg_dst=0, alu_src_b=1. Instruction takes 8 cycles total.
- BEQ/BNE with zero=1 → BEQ gives pc_write=1, pc_src=1 in EXEC; BNE gives pc_write=0. Neither asserts reg_write. JMP retires from DECODE with pc_src=2 after 2 cycles.
- MUL with MUL_LAT=4 → EXEC held exactly 4 cycles with alu_op=1000, then WB with flag_write=1. Asserting stall for 2 cycles mid-EXEC extends EXEC to 6 cycles, with strobes 0 while stalled.
- Counter wrap with CNT_W=4 → after 16 retired instructions retired reads 0. An rst asserted during MEM of an SW gives no instr_done and no further dmem_we.
